// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - state encoding, default sizes and two's-complement helpers for mul_hilo_unit
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } mul_state_t;

  localparam int MUL_WIDTH_DEFAULT  = 16;
  localparam int MUL_CYCLES_DEFAULT = 2 * MUL_WIDTH_DEFAULT;

  // Helpers work at 64 bits; callers size-cast the result back to their width.
  function automatic logic [63:0] twos_neg(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  function automatic logic [63:0] abs_mag(input logic [63:0] v, input logic neg);
    return neg ? twos_neg(v) : v;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - IDLE/RUN/WB sequencer with fixed-latency counter for the multiplier
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic mul_sy,
  output logic capture
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  mul_state_t    state;
  logic [CW-1:0] cnt;

  assign mul_sy  = start && (state == ST_IDLE);
  assign capture = (state == ST_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt   <= CW'(MUL_CYCLES - 1);
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt == '0) state <= ST_WB;
          else           cnt   <= cnt - 1'b1;
        end
        ST_WB: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mul_hilo_unit.sv
// rtl/mul_hilo_unit.sv - MULT issue/writeback around the shift-add multiplier, HI/LO registers
// Optional signed MULT support is compiled in with `define MUL_SIGNED_EN.
module mul_hilo_unit
  import mul_pkg::*;
#(
  parameter int WIDTH      = MUL_WIDTH_DEFAULT,
  parameter int MUL_CYCLES = 2 * WIDTH
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   OpA,
  input  logic [WIDTH-1:0]   OpB,
  input  logic               SignedOp,
  input  logic               MtHi,
  input  logic               MtLo,
  input  logic [WIDTH-1:0]   WrData,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Hi,
  output logic [WIDTH-1:0]   Lo,
  output logic [WIDTH-1:0]   MulMultiplicando,
  output logic [WIDTH-1:0]   MulMultiplicador,
  output logic [WIDTH-1:0]   MulMultiplicandoReg,
  output logic               MulSy,
  input  logic [2*WIDTH-1:0] MulProduto
);

  localparam int PW = 2 * WIDTH;

  logic             capture;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] mcand_reg, mplier_reg;
  logic [PW-1:0]    result;

  mul_seq_ctrl #(.MUL_CYCLES(MUL_CYCLES)) u_ctrl (
    .clk     (Clk),
    .rst_n   (Reset),
    .start   (Start),
    .busy    (Busy),
    .done    (Done),
    .mul_sy  (MulSy),
    .capture (capture)
  );

`ifdef MUL_SIGNED_EN
  logic sign_a, sign_b, neg_flag;

  assign sign_a = SignedOp & OpA[WIDTH-1];
  assign sign_b = SignedOp & OpB[WIDTH-1];
  assign mag_a  = WIDTH'(abs_mag(64'(OpA), sign_a));
  assign mag_b  = WIDTH'(abs_mag(64'(OpB), sign_b));
  assign result = neg_flag ? PW'(twos_neg(64'(MulProduto))) : MulProduto;

  // Result sign is decided at accept time, since OpA/OpB are not held by the execute stage.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)     neg_flag <= 1'b0;
    else if (MulSy) neg_flag <= sign_a ^ sign_b;
  end
`else
  logic unused_signed;

  assign unused_signed = SignedOp;
  assign mag_a         = OpA;
  assign mag_b         = OpB;
  assign result        = MulProduto;
`endif

  assign MulMultiplicando    = MulSy ? mag_a : mcand_reg;
  assign MulMultiplicador    = MulSy ? mag_b : mplier_reg;
  assign MulMultiplicandoReg = mcand_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else if (MulSy) begin
      mcand_reg  <= mag_a;
      mplier_reg <= mag_b;
    end
  end

  // MT writes are only honoured while idle; a MULT accepted alongside one overwrites it later.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Hi <= '0;
      Lo <= '0;
    end else if (capture) begin
      {Hi, Lo} <= result;
    end else if (!Busy) begin
      if (MtHi) Hi <= WrData;
      if (MtLo) Lo <= WrData;
    end
  end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb/tb_mul_hilo_unit.sv - directed vector bench for mul_hilo_unit with a behavioural multiplier
module tb_mul_hilo_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] OpA, OpB;
  logic        SignedOp;
  logic        MtHi, MtLo;
  logic [15:0] WrData;
  logic        Busy, Done;
  logic [15:0] Hi, Lo;
  logic [15:0] MulMultiplicando, MulMultiplicador, MulMultiplicandoReg;
  logic        MulSy;
  logic [31:0] MulProduto;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mul_hilo_unit #(.WIDTH(16), .MUL_CYCLES(32)) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .Start               (Start),
    .OpA                 (OpA),
    .OpB                 (OpB),
    .SignedOp            (SignedOp),
    .MtHi                (MtHi),
    .MtLo                (MtLo),
    .WrData              (WrData),
    .Busy                (Busy),
    .Done                (Done),
    .Hi                  (Hi),
    .Lo                  (Lo),
    .MulMultiplicando    (MulMultiplicando),
    .MulMultiplicador    (MulMultiplicador),
    .MulMultiplicandoReg (MulMultiplicandoReg),
    .MulSy               (MulSy),
    .MulProduto          (MulProduto)
  );

  // Multiplier model: product only becomes valid 32 edges after the MulSy edge.
  logic [31:0] model_prod;
  int          model_cnt;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      model_prod <= 32'd0;
      model_cnt  <= 40;
    end else if (MulSy) begin
      model_prod <= 32'(MulMultiplicando) * 32'(MulMultiplicador);
      model_cnt  <= 0;
    end else if (model_cnt < 32) begin
      model_cnt <= model_cnt + 1;
    end
  end

  assign MulProduto = (model_cnt >= 32) ? model_prod : 32'hDEADBEEF;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] exp;
    logic [15:0] mcand;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives Start for one edge; returns at the negedge right after the accept edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge Clk);
    OpA = a; OpB = b; SignedOp = s; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!Done && lat < 100) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  int lat;
  int nd;
  bit sgn;

  initial begin
`ifdef MUL_SIGNED_EN
    sgn = 1'b1;
`else
    sgn = 1'b0;
`endif
    tbl[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16'hFFFF};
    tbl[1] = '{16'd1234, 16'd5678, 1'b0, 32'h006AE9BC, 16'd1234};
    tbl[2] = '{16'h0000, 16'h0007, 1'b0, 32'h00000000, 16'h0000};
    tbl[3] = '{16'hFFFD, 16'h0007, 1'b1, sgn ? 32'hFFFFFFEB : 32'h0006FFEB, sgn ? 16'h0003 : 16'hFFFD};
    tbl[4] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000, 16'h8000};
    tbl[5] = '{16'h8000, 16'h0003, 1'b1, sgn ? 32'hFFFE8000 : 32'h00018000, 16'h8000};
    tbl[6] = '{16'h0007, 16'hFFFF, 1'b1, sgn ? 32'hFFFFFFF9 : 32'h0006FFF9, 16'h0007};
    tbl[7] = '{16'hFFFD, 16'h0007, 1'b0, 32'h0006FFEB, 16'hFFFD};

    Reset = 1'b0; Start = 1'b0; OpA = '0; OpB = '0; SignedOp = 1'b0;
    MtHi = 1'b0; MtLo = 1'b0; WrData = '0;
    #1;
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_mulsy", 32'(MulSy), 32'd0);
    check("reset_hilo", {Hi, Lo}, 32'd0);
    check("reset_mcand_reg", 32'(MulMultiplicandoReg), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].s);
      check($sformatf("vec%0d_mcand_reg", i), 32'(MulMultiplicandoReg), 32'(tbl[i].mcand));
      check($sformatf("vec%0d_busy", i), 32'(Busy), 32'd1);
      wait_done(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
      check($sformatf("vec%0d_hilo", i), {Hi, Lo}, tbl[i].exp);
      @(negedge Clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(Done), 32'd0);
    end

    // MTHI alone, then MTHI+MTLO together, then MTLO while busy.
    MtHi = 1'b1; WrData = 16'hABCD;
    @(negedge Clk);
    MtHi = 1'b0;
    check("mthi_hi", 32'(Hi), 32'h0000ABCD);
    check("mthi_lo_kept", 32'(Lo), 32'h0000FFEB);
    MtHi = 1'b1; MtLo = 1'b1; WrData = 16'h1357;
    @(negedge Clk);
    MtHi = 1'b0; MtLo = 1'b0;
    check("mthilo_both", {Hi, Lo}, 32'h13571357);
    start_op(16'd3, 16'd5, 1'b0);
    @(negedge Clk);
    MtLo = 1'b1; WrData = 16'hFFFF;
    @(negedge Clk);
    MtLo = 1'b0;
    check("mtlo_busy_ignored", 32'(Lo), 32'h00001357);
    wait_done(lat);
    check("mtlo_busy_result", {Hi, Lo}, 32'd15);

    // MTHI in the same cycle as an accepted MULT.
    @(negedge Clk);
    OpA = 16'd2; OpB = 16'd3; SignedOp = 1'b0; Start = 1'b1; MtHi = 1'b1; WrData = 16'h2222;
    #1;
    check("accept_mulsy", 32'(MulSy), 32'd1);
    check("accept_mcand_mux", 32'(MulMultiplicando), 32'd2);
    @(negedge Clk);
    Start = 1'b0; MtHi = 1'b0;
    check("mt_with_start_hi", 32'(Hi), 32'h00002222);
    check("mt_with_start_busy", 32'(Busy), 32'd1);
    wait_done(lat);
    check("mt_with_start_latency", 32'(lat), 32'd33);
    check("mt_with_start_hilo", {Hi, Lo}, 32'd6);

    // Start while busy is dropped, not queued.
    start_op(16'd4, 16'd5, 1'b0);
    repeat (3) @(negedge Clk);
    OpA = 16'd9; OpB = 16'd9; Start = 1'b1;
    #1;
    check("busy_mulsy_low", 32'(MulSy), 32'd0);
    repeat (2) @(negedge Clk);
    Start = 1'b0;
    nd = 0;
    repeat (60) begin
      @(negedge Clk);
      if (Done) nd++;
    end
    check("busy_start_done_count", 32'(nd), 32'd1);
    check("busy_start_hilo", {Hi, Lo}, 32'd20);
    check("busy_start_idle", 32'(Busy), 32'd0);

    // Asynchronous reset in the middle of RUN.
    start_op(16'd3, 16'd5, 1'b0);
    repeat (5) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("midrun_reset_busy", 32'(Busy), 32'd0);
    check("midrun_reset_hilo", {Hi, Lo}, 32'd0);
    check("midrun_reset_mcand_reg", 32'(MulMultiplicandoReg), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    nd = 0;
    repeat (50) begin
      @(negedge Clk);
      if (Done) nd++;
    end
    check("midrun_reset_no_done", 32'(nd), 32'd0);

    // Back-to-back: new Start on the Done cycle is accepted at once.
    start_op(16'd1234, 16'd5678, 1'b0);
    wait_done(lat);
    check("b2b_first_latency", 32'(lat), 32'd33);
    check("b2b_first_hilo", {Hi, Lo}, 32'h006AE9BC);
    OpA = 16'd0; OpB = 16'd7; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("b2b_second_accepted", 32'(Busy), 32'd1);
    wait_done(lat);
    check("b2b_second_latency", 32'(lat), 32'd33);
    check("b2b_second_hilo", {Hi, Lo}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
